// File: rtl/block_write_buffer.sv
// block_write_buffer: DEPTH-entry FIFO of 4-word blocks drained one word per accepted cycle to a memory write port.
// Optional write combining onto the tail entry is enabled by defining BLOCK_WRITE_COMBINE_EN.
module block_write_buffer #(
    parameter int DEPTH = 2,
    parameter int AW    = 15,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [AW-1:0]            in_addr,
    input  logic [DW-1:0]            in_data [0:3],
    output logic                     mem_we,
    input  logic                     mem_ready,
    output logic [AW-1:0]            mem_addr,
    output logic [DW-1:0]            mem_wdata,
    output logic                     blk_done,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy
);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t         state_q, state_d;
    logic [PW-1:0]  head_q, head_d, tail_q, tail_d;
    logic [PW:0]    count_q, count_d;
    logic [1:0]     wcnt_q, wcnt_d;
    logic [AW-1:0]  base_q [DEPTH];
    logic [AW-1:0]  base_d [DEPTH];
    logic [DW-1:0]  data_q [DEPTH][4];
    logic [DW-1:0]  data_d [DEPTH][4];
    logic [AW-1:0]  in_base;
    logic           full, combine_hit, push, pop, acc;

    assign in_base = in_addr & ~AW'(3);
    assign full    = count_q == (PW+1)'(DEPTH);

`ifdef BLOCK_WRITE_COMBINE_EN
    logic [PW-1:0] last;
    assign last        = tail_q - 1'b1;
    // the newest entry may be rewritten unless it is the block already draining
    assign combine_hit = in_valid && count_q != '0 && base_q[last] == in_base &&
                         !(state_q == DRAIN && last == head_q);
    assign in_ready    = !full || combine_hit;
`else
    assign combine_hit = 1'b0;
    assign in_ready    = !full;
`endif

    assign acc      = state_q == DRAIN && mem_ready;
    assign pop      = acc && wcnt_q == 2'd3;
    assign push     = in_valid && in_ready && !combine_hit;
    assign mem_we   = state_q == DRAIN;
    assign mem_addr = mem_we ? (base_q[head_q] | AW'(wcnt_q)) : '0;
    assign mem_wdata = mem_we ? data_q[head_q][wcnt_q] : '0;
    assign blk_done = pop;
    assign count    = count_q;
    assign busy     = count_q != '0;

    // next-state: FIFO storage, pointers, occupancy, word counter and drain state
    always_comb begin
        base_d = base_q;
        data_d = data_q;
        if (push) begin
            base_d[tail_q] = in_base;
            for (int i = 0; i < 4; i++) data_d[tail_q][i] = in_data[i];
        end
`ifdef BLOCK_WRITE_COMBINE_EN
        if (combine_hit)
            for (int i = 0; i < 4; i++) data_d[last][i] = in_data[i];
`endif
        head_d  = head_q + PW'(pop);
        tail_d  = tail_q + PW'(push);
        count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
        wcnt_d  = wcnt_q + 2'(acc);
        state_d = count_d != '0 ? DRAIN : IDLE;
    end

    // state registers; reset discards all buffered blocks and drops mem_we at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            wcnt_q  <= '0;
            base_q  <= '{default: '0};
            data_q  <= '{default: '0};
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            wcnt_q  <= wcnt_d;
            base_q  <= base_d;
            data_q  <= data_d;
        end
    end
endmodule

// File: doc/block_write_buffer.md
Name: block_write_buffer

Overview:
- Write-side counterpart of the cache's 4-word block main-memory read path: accepts whole 4-word blocks from the cache controller (evictions / write-through) and drains them into a word-wide memory write port, one word per accepted cycle.
- Decouples the cache from memory write latency with a DEPTH-entry block FIFO.
- Sits between the cache controller and the main data memory.

Parameters:
- DEPTH, 2, number of buffered blocks (power of 2, >=2)
- AW, 15, word address width
- DW, 32, data word width

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  block write request valid
- in_ready  output  1  buffer can accept a block this cycle
- in_addr  input  AW  any word address inside the target block
- in_data  input  4xDW  unpacked [0:3]; in_data[i] goes to block base + i
- mem_we  output  1  word write strobe
- mem_ready  input  1  memory accepts the word this cycle
- mem_addr  output  AW  word write address
- mem_wdata  output  DW  word write data
- blk_done  output  1  one-cycle pulse: last word of a block accepted
- count  output  $clog2(DEPTH)+1  blocks currently held
- busy  output  1  count != 0

Behaviour:
- Reset (async, rst_n=0): FIFO emptied, word counter=0, state IDLE; in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, blk_done=0, count=0, busy=0. All in-flight data is discarded. mem_we drops immediately, without waiting for a clock edge.
- Storage: on push, store base = {in_addr[AW-1:2],2'b00} and all 4 words.
- Push: occurs when in_valid && in_ready. in_ready = (count != DEPTH), from registered count only.
  - With the buffer full, a push is never accepted, even in a cycle where a pop occurs.
  - in_valid with in_ready=0 is ignored. Sender holds the request.
- FSM states:
  - IDLE: mem_we=0. Go to DRAIN on the next edge if count != 0 (includes a block pushed this cycle). First mem_we appears the cycle after acceptance; minimum latency is 1 cycle.
  - DRAIN: mem_we=1, mem_addr = head.base + wcnt, mem_wdata = head.data[wcnt], wcnt is 2 bits.
    - A word is accepted when mem_we && mem_ready; wcnt then increments.
    - mem_ready=0: outputs stay stable, wcnt holds.
    - On acceptance with wcnt==3: pop head, wcnt=0, blk_done=1 for that cycle (combinational with the final acceptance).
    - After that acceptance: stay in DRAIN if count after pop != 0 (no bubble); else go to IDLE.
- Address arithmetic: base low bits are 00, so base+wcnt never carries out of bits [1:0]. No wrap across blocks. Base 0x7FFC drains 0x7FFC..0x7FFF.
- Simultaneous push and pop (not full): count unchanged. Pushed entry lands at tail and is drained in FIFO order.
- FIFO pointers wrap modulo DEPTH.
- Best case: one block takes 4 cycles of mem_we; sustained throughput is 1 block per 4 cycles.

Optional Feature:
- Macro: BLOCK_WRITE_COMBINE_EN
- Defined:
  - If in_valid and aligned in_addr equals the tail entry's base, and the tail is not the head currently in DRAIN, the tail's 4 data words are overwritten.
  - This is accepted even when full (in_ready = !full || combine_hit); count is unchanged.
  - A head in DRAIN is never modified; a matching push onto it allocates a new entry normally.
- Undefined: no address compare. Every push allocates an entry. Duplicate addresses are drained twice, in order.

Test Plan:
- Reset then single push, in_addr=0x0105, in_data={A0,A1,A2,A3}, mem_ready=1 -> no mem_we in push cycle. Next 4 cycles write 0x0104=A0, 0x0105=A1, 0x0106=A2, 0x0107=A3. blk_done in 4th cycle. busy=0 after.
- Back-to-back pushes 0x0010 and 0x7FFC, mem_ready=1 -> 8 consecutive mem_we cycles with no bubble. Addresses 0x0010..0x0013 then 0x7FFC..0x7FFF. count 2->1->0.
- Fill to DEPTH=2 with mem_ready=0 -> in_ready=0. Third push held off. mem_addr/mem_wdata stable at word 0. Raise mem_ready: third push accepted only on the cycle after the first pop.
- mem_ready toggling 1,0,1,0 during drain -> each word is presented until accepted. Exactly 4 writes per block, correct data, no duplicates.
- Assert rst_n=0 mid-block, after 2 words -> mem_we=0 immediately, count=0, in_ready=1. After release, no further writes occur.
- BLOCK_WRITE_COMBINE_EN defined: push 0x0040 {1,2,3,4}, then 0x0080 {5,6,7,8}, then 0x0081 {9,10,11,12} while the first is draining -> count stays 2. 0x0080..0x0083 receive 9,10,11,12. Undefined: 12 writes total.
